// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge detection, run/pause/lap state machine,
// and the 1/TICK_HZ prescaler feeding the time counter.
module stopwatch_ctrl #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100,
    localparam int DIV    = CLK_HZ / TICK_HZ,
    localparam int DIV_W  = $clog2(DIV)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_stop,
    input  logic lap_reset,
    output logic run,
    output logic tick,
    output logic clear,
    output logic freeze
);

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        PAUSED,
        LAP
    } state_t;

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    state_t           state;
    state_t           state_nxt;
    logic             ss_prev;
    logic             lr_prev;
    logic             ss_ev;
    logic             lr_ev;
    logic             clr_nxt;
    logic [DIV_W-1:0] presc;

    // start_stop has priority over a coincident lap_reset event
    assign ss_ev = start_stop & ~ss_prev;
    assign lr_ev = lap_reset & ~lr_prev & ~ss_ev;

    always_comb begin
        state_nxt = state;
        clr_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (ss_ev) state_nxt = RUNNING;
                else if (lr_ev) clr_nxt = 1'b1;
            end
            RUNNING: begin
                if (ss_ev) state_nxt = PAUSED;
                else if (lr_ev) state_nxt = LAP;
            end
            LAP: begin
                if (ss_ev) state_nxt = PAUSED;
                else if (lr_ev) state_nxt = RUNNING;
            end
            PAUSED: begin
                if (ss_ev) state_nxt = RUNNING;
                else if (lr_ev) begin
                    state_nxt = IDLE;
                    clr_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ss_prev <= 1'b0;
            lr_prev <= 1'b0;
            presc   <= '0;
            run     <= 1'b0;
            tick    <= 1'b0;
            clear   <= 1'b0;
            freeze  <= 1'b0;
        end else begin
            ss_prev <= start_stop;
            lr_prev <= lap_reset;
            state   <= state_nxt;
            run     <= (state_nxt == RUNNING) || (state_nxt == LAP);
            freeze  <= (state_nxt == LAP);
            clear   <= clr_nxt;
            // run is the registered value, so the stopping edge still ticks
            tick    <= run && (presc == LAST);
            if (clr_nxt) begin
                presc <= '0;
            end else if (run) begin
                presc <= (presc == LAST) ? '0 : presc + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV = 10; a per-cycle reference
// model feeds an expected-output queue that is drained as the DUT responds.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start_stop;
    logic lap_reset;
    logic run;
    logic tick;
    logic clear;
    logic freeze;

    stopwatch_ctrl #(
        .CLK_HZ (1000),
        .TICK_HZ(100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_stop(start_stop),
        .lap_reset (lap_reset),
        .run       (run),
        .tick      (tick),
        .clear     (clear),
        .freeze    (freeze)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] v;
    } exp_t;

    exp_t sb[$];
    int   ticks[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // reference model: 0 idle, 1 running, 2 paused, 3 lap
    int m_st;
    int m_pre;
    bit m_ssp, m_lrp;
    bit m_run, m_tick, m_clear, m_freeze;

    task automatic model_reset();
        m_st = 0; m_pre = 0; m_ssp = 0; m_lrp = 0;
        m_run = 0; m_tick = 0; m_clear = 0; m_freeze = 0;
    endtask

    task automatic model_step();
        bit ev_ss, ev_lr;
        int n_st;
        ev_ss = start_stop && !m_ssp;
        ev_lr = lap_reset && !m_lrp && !ev_ss;
        m_ssp = start_stop;
        m_lrp = lap_reset;
        m_tick = m_run && (m_pre == 9);
        m_clear = 0;
        n_st = m_st;
        case (m_st)
            0: if (ev_ss) n_st = 1; else if (ev_lr) m_clear = 1;
            1: if (ev_ss) n_st = 2; else if (ev_lr) n_st = 3;
            3: if (ev_ss) n_st = 2; else if (ev_lr) n_st = 1;
            default: if (ev_ss) n_st = 1;
                     else if (ev_lr) begin n_st = 0; m_clear = 1; end
        endcase
        if (m_clear) m_pre = 0;
        else if (m_run) m_pre = (m_pre + 1) % 10;
        m_st = n_st;
        m_run = (n_st == 1) || (n_st == 3);
        m_freeze = (n_st == 3);
    endtask

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(string tag);
        exp_t e;
        logic [3:0] obs;
        model_step();
        e.tag = tag;
        e.v = {m_run, m_tick, m_clear, m_freeze};
        sb.push_back(e);
        @(posedge clk);
        #1;
        cycle++;
        if (tick) ticks.push_back(cycle);
        e = sb.pop_front();
        obs = {run, tick, clear, freeze};
        checks++;
        assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s cyc %0d: observed rtcf=%b expected rtcf=%b",
                   e.tag, cycle, obs, e.v);
        end
    endtask

    task automatic steps(string tag, int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic pulse_ss(string tag);
        start_stop = 1'b1;
        step(tag);
        start_stop = 1'b0;
    endtask

    task automatic pulse_lr(string tag);
        lap_reset = 1'b1;
        step(tag);
        lap_reset = 1'b0;
    endtask

    initial begin
        int c0;
        int rises;
        bit prev_run;
        rst_n = 1'b0;
        start_stop = 1'b0;
        lap_reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", int'({run, tick, clear, freeze}), 0);
        rst_n = 1'b1;
        steps("idle", 3);

        // steady run: 10 ticks in 100 cycles, spaced 10 apart
        pulse_ss("start");
        c0 = cycle;
        chk("start_run", int'(run), 1);
        ticks.delete();
        steps("steady", 100);
        chk("steady_count", ticks.size(), 10);
        if (ticks.size() > 0) chk("steady_first", ticks[0] - c0, 10);
        for (int i = 1; i < ticks.size(); i++)
            chk("steady_space", ticks[i] - ticks[i-1], 10);

        // pause with the prescaler holding 4
        steps("pre_pause", 3);
        pulse_ss("pause");
        ticks.delete();
        steps("paused", 37);
        chk("paused_noticks", ticks.size(), 0);
        chk("paused_run", int'(run), 0);
        pulse_ss("resume");
        c0 = cycle;
        steps("resumed", 10);
        if (ticks.size() > 0) chk("resume_first", ticks[0] - c0, 6);
        else chk("resume_first_missing", 0, 1);

        // lap keeps time running and the tick cadence intact
        pulse_lr("lap_on");
        chk("lap_freeze", int'(freeze), 1);
        steps("lap", 20);
        pulse_lr("lap_off");
        chk("lap_off_freeze", int'(freeze), 0);
        steps("after_lap", 15);
        chk("lap_tick_count", ticks.size(), 5);
        for (int i = 1; i < ticks.size(); i++)
            chk("lap_space", ticks[i] - ticks[i-1], 10);
        pulse_lr("lap_again");
        steps("lap2", 3);
        pulse_ss("lap_to_pause");
        chk("lap_pause_run", int'(run), 0);
        chk("lap_pause_freeze", int'(freeze), 0);
        steps("paused2", 4);

        // clear from PAUSED, again from IDLE, then a fresh start
        pulse_lr("clear_paused");
        chk("clear_paused", int'(clear), 1);
        step("clear_drop");
        chk("clear_one_cycle", int'(clear), 0);
        steps("idle2", 2);
        pulse_lr("clear_idle");
        chk("clear_idle", int'(clear), 1);
        steps("idle3", 2);
        pulse_ss("start2");
        c0 = cycle;
        ticks.delete();
        steps("run2", 9);
        pulse_ss("stop_at_last");
        chk("final_tick", int'(tick), 1);
        chk("final_tick_run", int'(run), 0);
        if (ticks.size() > 0) chk("start2_first", ticks[0] - c0, 10);

        // a level held 50 cycles gives a single transition
        steps("paused3", 2);
        start_stop = 1'b1;
        rises = 0;
        prev_run = run;
        for (int i = 0; i < 50; i++) begin
            step("held");
            if (run && !prev_run) rises++;
            prev_run = run;
        end
        start_stop = 1'b0;
        chk("held_rises", rises, 1);
        chk("held_run", int'(run), 1);
        steps("held_rel", 3);

        // simultaneous events: start_stop wins
        start_stop = 1'b1;
        lap_reset = 1'b1;
        step("simul");
        chk("simul_state", int'({run, clear, freeze}), 0);
        start_stop = 1'b0;
        lap_reset = 1'b0;
        steps("simul_rel", 3);

        // asynchronous reset mid-run
        pulse_ss("run_before_rst");
        steps("pre_rst", 5);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset", int'({run, tick, clear, freeze}), 0);
        model_reset();
        #2 rst_n = 1'b1;
        steps("post_rst", 2);
        pulse_ss("start_after_rst");
        c0 = cycle;
        chk("rst_start_run", int'(run), 1);
        ticks.delete();
        steps("run_after_rst", 12);
        if (ticks.size() > 0) chk("rst_first_tick", ticks[0] - c0, 10);
        else chk("rst_first_tick_missing", 0, 1);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
